rv32i_mem_arbiter: RTL
======================

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of the address, write-data and read-data buses.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-port request; bit0 = core port, bit1 = loader/debug port.
REQ-005 req_ready  output  2  per-port accept strobe; request is consumed in the cycle where valid and ready are both 1.
REQ-006 req_addr0, req_addr1  input  ADDR_W  per-port byte address.
REQ-007 req_wr_data0, req_wr_data1  input  ADDR_W  per-port write data.
REQ-008 req_wr_ena  input  2  per-port write (1) / read (0) select.
REQ-009 rsp_valid  output  2  one-cycle read-response strobe, per port.
REQ-010 rsp_data  output  ADDR_W  read data, shared by both ports; qualified by rsp_valid.
REQ-011 mem_addr, mem_wr_data  output  ADDR_W  to the single-port memory.
REQ-012 mem_wr_ena  output  1  memory write strobe.
REQ-013 mem_rd_data  input  ADDR_W  memory read data, valid one cycle after the address is presented.
REQ-014 busy  output  1  high while state = READ_WAIT.

Function
REQ-015 FSM states SHALL be IDLE and READ_WAIT; no other states.
REQ-016 In IDLE with req_valid != 0, the winner SHALL be selected combinationally, its req_ready bit SHALL be 1 and the loser's bit 0, in the same cycle.
REQ-017 The granted port's address, write data and write select SHALL drive mem_addr, mem_wr_data and mem_wr_ena in the grant cycle.
REQ-018 A granted write SHALL complete in the grant cycle, produce no rsp_valid, and leave the FSM in IDLE; back-to-back writes SHALL sustain 1 per cycle.
REQ-019 A granted read SHALL move IDLE->READ_WAIT and latch the owner port; in READ_WAIT, rsp_data = mem_rd_data, rsp_valid[owner] = 1 for exactly that cycle, then READ_WAIT->IDLE.
REQ-020 In READ_WAIT, req_ready SHALL be 2'b00, mem_wr_ena 0 and mem_addr held at the latched read address; read throughput SHALL be 1 per 2 cycles.
REQ-021 With no grant, mem_addr, mem_wr_data and mem_wr_ena SHALL be 0; rsp_data SHALL be 0 whenever rsp_valid = 0.
REQ-022 last_grant (1 bit) SHALL be updated to the winner's index on every accepted request.
REQ-023 Single requester: that port SHALL always win, regardless of last_grant.
REQ-024 Requests presented during READ_WAIT SHALL be held by requesters and arbitrated in the following IDLE cycle; the arbiter SHALL NOT record them.

Reset
REQ-025 On rst, state SHALL go to IDLE, last_grant to 1 (port 0 wins the first contention), and the owner register to 0.
REQ-026 During and one cycle after rst, req_ready, rsp_valid, mem_wr_ena and busy SHALL be 0.
REQ-027 rst asserted in READ_WAIT SHALL abort the read; no rsp_valid for it SHALL ever be issued.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on contention, grant SHALL go to the port not equal to last_grant (alternating).
REQ-029 ARB_ROUND_ROBIN_EN undefined: on contention, port 0 SHALL always win; last_grant is still maintained but does not affect arbitration.

Verification
REQ-030 Port0 write addr 0x100 data 0xDEADBEEF, port1 idle -> req_ready=2'b01, mem_wr_ena=1, mem_addr=0x100 same cycle; no rsp_valid.
REQ-031 Port1 read 0x200, memory returns 0x12345678 -> busy=1 next cycle, rsp_valid=2'b10, rsp_data=0x12345678 in that cycle, then IDLE.
REQ-032 Both ports hold write requests for 4 accepted transfers after reset -> with macro grants 0,1,0,1; without macro grants 0,0,0,0.
REQ-033 Port0 read 0x10 accepted, port1 asserts a write in READ_WAIT -> req_ready=2'b00 in READ_WAIT; port1 write accepted in the next IDLE cycle.
REQ-034 rst pulsed in READ_WAIT -> no rsp_valid is issued; after release, a port0 write is accepted on the first valid cycle.
REQ-035 Port0 issues 3 back-to-back writes 0x0, 0x4, 0x8 -> accepted on 3 consecutive cycles with matching mem_addr.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: core (port 0) and
// loader/debug (port 1).
// Writes complete in the grant cycle. Reads hold the memory for one extra
// cycle while the registered read data comes back.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention.
// Without it, port 0 always wins a contention.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate; a granted write finishes here, a read moves on
// READ_WAIT | memory returns read data; response strobed to the owner
module rv32i_mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [ADDR_W-1:0] req_wr_data0,
   input  logic [ADDR_W-1:0] req_wr_data1,
   input  logic [1:0]        req_wr_ena,
   output logic [1:0]        rsp_valid,
   output logic [ADDR_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_wr_data,
   output logic              mem_wr_ena,
   input  logic [ADDR_W-1:0] mem_rd_data,
   output logic              busy
);

   typedef enum logic {IDLE, READ_WAIT} state_t;

   state_t            state, state_nxt;
   logic              last_grant, last_grant_nxt;
   logic              owner, owner_nxt;
   logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
   logic              win;

   // Winner selection: a lone requester always wins; contention follows the build option
   always_comb begin
      win = 1'b0;
      case (req_valid)
         2'b10:   win = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
         2'b11:   win = ~last_grant;
`else
         2'b11:   win = 1'b0;
`endif
         default: win = 1'b0;
      endcase
   end

   // Next-state and output decode; rst masks every strobe so nothing leaks while resetting
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      owner_nxt      = owner;
      rd_addr_nxt    = rd_addr;
      req_ready      = 2'b00;
      rsp_valid      = 2'b00;
      rsp_data       = '0;
      mem_addr       = '0;
      mem_wr_data    = '0;
      mem_wr_ena     = 1'b0;
      busy           = 1'b0;
      case (state)
         IDLE: begin
            if (!rst && (req_valid != 2'b00)) begin
               req_ready[win] = 1'b1;
               mem_addr       = win ? req_addr1 : req_addr0;
               mem_wr_data    = win ? req_wr_data1 : req_wr_data0;
               mem_wr_ena     = req_wr_ena[win];
               last_grant_nxt = win;
               if (!req_wr_ena[win]) begin
                  state_nxt   = READ_WAIT;
                  owner_nxt   = win;
                  rd_addr_nxt = mem_addr;
               end
            end
         end
         READ_WAIT: begin
            // Address is held so the memory keeps presenting the same word
            mem_addr  = rd_addr;
            state_nxt = IDLE;
            if (!rst) begin
               busy             = 1'b1;
               rsp_valid[owner] = 1'b1;
               rsp_data         = mem_rd_data;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; last_grant resets to 1 so port 0 takes the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         rd_addr    <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         owner      <= owner_nxt;
         rd_addr    <= rd_addr_nxt;
      end
   end

endmodule
